// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and restoring divide; one op in flight.
// Latency WIDTH+2 cycles (1 for divide-by-zero); start is only accepted while idle, never queued.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] work_hi, work_lo, opnd;
  logic             is_div, neg_res, neg_rem;

  // op[1] selects divide, op[0] selects unsigned
  logic             op_signed, a_neg, b_neg, by_zero;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign op_signed = ~op[0];
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;
  assign by_zero   = op[1] && (b == '0);

  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // Multiply keeps {work_hi, work_lo} as the partial product with the
  // multiplier shifting out of work_lo; divide keeps remainder in work_hi
  // and shifts the dividend out / quotient in through work_lo.
  assign addend   = work_lo[0] ? opnd : '0;
  assign sum      = {1'b0, work_hi} + {1'b0, addend};
  assign shifted  = {work_hi, work_lo[WIDTH-1]};
  assign ge       = shifted >= {1'b0, opnd};
  assign diff     = shifted[WIDTH-1:0] - opnd;
  assign prod_neg = -{work_hi, work_lo};

  always_comb begin
    fix_hi = work_hi;
    fix_lo = work_lo;
    if (is_div) begin
      if (neg_rem) fix_hi = -work_hi;
      if (neg_res) fix_lo = -work_lo;
    end else if (neg_res) begin
      fix_hi = prod_neg[2*WIDTH-1:WIDTH];
      fix_lo = prod_neg[WIDTH-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = by_zero ? DONE : CALC;
      CALC: if (cnt == LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            is_div   <= op[1];
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= by_zero;
            work_hi  <= '0;
            work_lo  <= op[1] ? mag_a : mag_b;
            opnd     <= op[1] ? mag_b : mag_a;
          end
        end
        CALC: begin
          cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
          if (is_div) begin
            work_hi <= ge ? diff : shifted[WIDTH-1:0];
            work_lo <= {work_lo[WIDTH-2:0], ge};
          end else begin
            work_hi <= sum[WIDTH:1];
            work_lo <= {sum[0], work_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          // Result registers update on the edge entering DONE so they are valid while done is high
          work_hi <= fix_hi;
          work_lo <= fix_lo;
          hi      <= fix_hi;
          lo      <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av, bv,
                        input int exp_lat, input logic [31:0] exp_hi, exp_lo,
                        input logic exp_dz, input bit disturb);
    int n;
    check({tag, "_done_low"}, done, 1'b0);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (n == 5) check({tag, "_hold"}, {hi, lo}, {prev_hi, prev_lo});
      if (disturb && n >= 5 && n <= 8) begin
        start = 1'b1; op = MULT; a = 32'h1234_5678; b = 32'h0000_0003;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_div_zero"}, div_zero, exp_dz);
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; op = MULT; a = '0; b = '0;
    #12;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_div_zero", div_zero, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd5, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
    @(negedge clk);
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'd2, 34, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    @(negedge clk);
    run_op("mult_negneg", MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 34, 32'h0, 32'h18, 1'b0, 1'b0);
    @(negedge clk);
    run_op("mult_minmin", MULT, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    run_op("div_neg_a", DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    @(negedge clk);
    run_op("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
    @(negedge clk);
    run_op("div_neg_b", DIV, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    @(negedge clk);
    run_op("divu_95_10", DIVU, 32'd95, 32'd10, 34, 32'd5, 32'd9, 1'b0, 1'b0);
    @(negedge clk);
    run_op("divu_zero", DIVU, 32'd7, 32'd0, 1, 32'd5, 32'd9, 1'b1, 1'b0);
    @(negedge clk);
    run_op("multu_2x3", MULTU, 32'd2, 32'd3, 34, 32'd0, 32'd6, 1'b0, 1'b0);
    @(negedge clk);
    run_op("divu_disturb", DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0, 1'b1);

    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("disturb_extra_done", pulses, 0);

    // Abort a divide mid-flight with an asynchronous reset
    start = 1'b1; op = DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    prev_hi = '0;
    prev_lo = '0;
    run_op("multu_4x4", MULTU, 32'd4, 32'd4, 34, 32'd0, 32'd16, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits; legal values are even numbers from 8 to 64.
REQ-002 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin an operation; sampled on the rising edge of clk.
REQ-005 Port: op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 Port: a  input  WIDTH  multiplicand or dividend; captured when start is accepted.
REQ-007 Port: b  input  WIDTH  multiplier or divisor; captured when start is accepted.
REQ-008 Port: hi  output  WIDTH  MULT/MULTU: upper product half; DIV/DIVU: remainder.
REQ-009 Port: lo  output  WIDTH  MULT/MULTU: lower product half; DIV/DIVU: quotient.
REQ-010 Port: busy  output  1  high from the cycle after acceptance until the cycle done is asserted, inclusive.
REQ-011 Port: done  output  1  one-cycle pulse; hi/lo are valid and stable in that cycle and afterwards.
REQ-012 Port: div_zero  output  1  sticky flag, set by DIV/DIVU with b==0 and cleared by the next accepted start.

Function
REQ-013 The state machine SHALL have states IDLE, CALC, FIX and DONE.
REQ-014 In IDLE, start=1 SHALL be accepted: a, b and op are captured, div_zero is cleared, and the next state is CALC.
REQ-015 start SHALL be ignored in every state other than IDLE; it is neither queued nor allowed to disturb the operation in flight.
REQ-016 An accepted DIV/DIVU with b==0 SHALL go directly to DONE, set div_zero=1, and leave hi/lo unchanged.
REQ-017 CALC SHALL last exactly WIDTH cycles, driven by an internal iteration counter; MULT uses shift-add and DIV uses restoring shift-subtract on operand magnitudes.
REQ-018 FIX SHALL last 1 cycle and apply the sign corrections, then move to DONE.
REQ-019 DONE SHALL last 1 cycle: it loads hi/lo, asserts done, and returns to IDLE.
REQ-020 Latency SHALL be WIDTH+2 cycles, measured as the number of rising edges from the edge that accepts start to the first edge at which done=1; for divide-by-zero the latency is 1.
REQ-021 A new start SHALL be acceptable in the cycle immediately after done.
REQ-022 MULT/MULTU SHALL produce {hi,lo} equal to the exact 2*WIDTH-bit product (two's-complement for MULT).
REQ-023 DIV quotient SHALL truncate toward zero, and the remainder sign SHALL equal the dividend sign, so that a == lo*b + hi.
REQ-024 DIVU SHALL produce an unsigned quotient and remainder.
REQ-025 DIV of the most-negative value by -1 SHALL give lo = most-negative value and hi = 0, with no flag raised.
REQ-026 hi/lo SHALL change only in DONE; during CALC and FIX they keep the previous result.

Reset
REQ-027 When reset is asserted, the block SHALL immediately, without waiting for clk, enter IDLE and force hi=0, lo=0, busy=0, done=0, div_zero=0, with the iteration counter and working registers at 0.
REQ-028 Reset asserted during CALC or FIX SHALL abort the operation; no done pulse is produced for it.
REQ-029 The first start SHALL be accepted on the first rising edge after reset is deasserted.

Verification (WIDTH=32)
REQ-030 MULT a=0xFFFFFFFD (-3), b=5 -> done 34 cycles after acceptance; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-031 MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 DIVU a=7, b=0 with hi/lo previously 5/9 -> done 1 cycle after acceptance, div_zero=1, hi/lo still 5/9; then MULTU 2*3 -> div_zero=0, lo=6.
REQ-034 DIVU 100/7 started, start toggled with op=MULT during CALC -> a single done after 34 cycles with hi=2, lo=14.
REQ-035 DIVU 100/7 started, reset pulsed at cycle 10 -> busy=0 and hi=lo=0 immediately; no done pulse; a following MULTU 4*4 gives lo=16.
